// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests and buffers returned instructions for IF/ID.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] discard_count
`endif
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] if_wr_q, if_wr_d, if_rd_q, if_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [31:0]   if_pc_q [DEPTH];
  logic [31:0]   if_pc_d [DEPTH];
  logic [31:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_pc_d [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic          req_fire, rsp_keep, rsp_drop, pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit check counts buffered plus in-flight entries so a response always has a free slot.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr_out      = instr_valid ? buf_instr_q[buf_rd_q] : NOP;
  assign pc_out         = instr_valid ? buf_pc_q[buf_rd_q] : 32'h0;

  always_comb begin
    req_fire      = imem_req_valid && imem_req_ready;
    rsp_drop      = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    rsp_keep      = imem_rsp_valid && !rsp_drop;
    pop           = instr_valid && !stall && !redirect_valid;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    if_wr_d       = if_wr_q;
    if_rd_d       = if_rd_q;
    buf_wr_d      = buf_wr_q;
    buf_rd_d      = buf_rd_q;
    if_pc_d       = if_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;

    if (req_fire) begin
      fetch_pc_d       = fetch_pc_q + 32'd4;
      if_pc_d[if_wr_q] = fetch_pc_q;
      if_wr_d          = if_wr_q + PW'(1);
    end
    if (imem_rsp_valid) begin
      if_rd_d = if_rd_q + PW'(1);
    end
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (rsp_keep) begin
      buf_pc_d[buf_wr_q]    = if_pc_q[if_rd_q];
      buf_instr_d[buf_wr_q] = imem_rsp_data;
      buf_wr_d              = buf_wr_q + PW'(1);
    end
    if (pop) begin
      buf_rd_d = buf_rd_q + PW'(1);
    end
    case ({rsp_keep, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    // No request fires on a redirect, so every request still in flight afterwards is stale.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      if_wr_q       <= '0;
      if_rd_q       <= '0;
      buf_wr_q      <= '0;
      buf_rd_q      <= '0;
      if_pc_q       <= '{default: '0};
      buf_pc_q      <= '{default: '0};
      buf_instr_q   <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      if_wr_q       <= if_wr_d;
      if_rd_q       <= if_rd_d;
      buf_wr_q      <= buf_wr_d;
      buf_rd_q      <= buf_rd_d;
      if_pc_q       <= if_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] discard_count_q, discard_count_d;
  logic [31:0] discard_inc;

  // Discards cover dropped responses plus any buffered entries flushed by a redirect.
  always_comb begin
    discard_inc = '0;
    if (redirect_valid) begin
      discard_inc = 32'(count_q);
    end
    if (rsp_drop) begin
      discard_inc = discard_inc + 32'd1;
    end
    fetch_count_d   = fetch_count_q + (pop ? 32'd1 : 32'd0);
    discard_count_d = discard_count_q + discard_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q   <= '0;
      discard_count_q <= '0;
    end else begin
      fetch_count_q   <= fetch_count_d;
      discard_count_q <= discard_count_d;
    end
  end

  assign fetch_count   = fetch_count_q;
  assign discard_count = discard_count_q;
`endif

  rsp_credit_a: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding_q == '0)));
  buf_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency in-order memory model.
// Perf-counter checks are compiled in only when FETCH_PERF_CNT_EN is defined.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] discard_count;
  logic [31:0] discardSnap;
`endif

  int errorCount = 0;
  int checkCount = 0;

  logic [2:0]  latSel = 3'd0;
  logic [7:0]  pipeValid;
  logic [31:0] pipeAddr [8];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .pc_out        (pc_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .discard_count (discard_count)
`endif
  );

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: an accepted request answers latSel+1 cycles later, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= '0;
      for (int i = 0; i < 8; i++) pipeAddr[i] <= '0;
    end else begin
      pipeValid   <= {pipeValid[6:0], imem_req_valid & imem_req_ready};
      pipeAddr[0] <= imem_req_addr;
      for (int i = 1; i < 8; i++) pipeAddr[i] <= pipeAddr[i-1];
    end
  end

  assign imem_rsp_valid = pipeValid[latSel];
  assign imem_rsp_data  = instrOf(pipeAddr[latSel]);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdv, input logic [31:0] rdpc, input logic st, input logic rdy);
    @(negedge clk);
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    stall          = st;
    imem_req_ready = rdy;
    #1;
  endtask

  task automatic expectHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({tag, "_pc"}, pc_out, pc);
    checkOutput({tag, "_instr"}, instr_out, instrOf(pc));
  endtask

  task automatic expectEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_nop"}, instr_out, NOP);
    checkOutput({tag, "_pc0"}, pc_out, 32'h0);
  endtask

  task automatic expectReq(input string tag, input logic vld, input logic [31:0] addr);
    checkOutput({tag, "_reqv"}, {31'b0, imem_req_valid}, {31'b0, vld});
    if (vld) checkOutput({tag, "_addr"}, imem_req_addr, addr);
  endtask

  // Leaves the bench sampling cycle 0, the first cycle after reset release.
  task automatic resetDut(input logic [2:0] lat);
    @(negedge clk);
    rst            = 1'b1;
    latSel         = lat;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    checkOutput("rst_reqv", {31'b0, imem_req_valid}, 32'd0);
    expectEmpty("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic reqExp [5];
    reqExp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    $display("[TB] streaming fetch, L=1");
    resetDut(3'd0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      expectReq("t1", 1'b1, 32'h100 + 32'(4 * k));
      if (k < 2) expectEmpty("t1_early");
      else       expectHead("t1", 32'h100 + 32'(4 * (k - 2)));
    end

    $display("[TB] stall for 5 cycles, then release");
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      expectHead("t2_stall", 32'h11C);
      checkOutput("t2_stall_reqv", {31'b0, imem_req_valid}, {31'b0, reqExp[s]});
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      expectHead("t2_drain", 32'h11C + 32'(4 * j));
    end

    $display("[TB] redirect with requests in flight, L=3");
    resetDut(3'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h2000, 1'b0, 1'b1);
    expectReq("t3_redir", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    discardSnap = discard_count;
`endif
    for (int c = 4; c <= 7; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      if (c == 4) expectReq("t3_first", 1'b1, 32'h2000);
`ifdef FETCH_PERF_CNT_EN
      if (c == 6) checkOutput("t3_discards", discard_count - discardSnap, 32'd3);
`endif
      expectEmpty("t3_gap");
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t3_new0", 32'h2000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t3_new1", 32'h2004);

    $display("[TB] redirect coinciding with response and stall");
    resetDut(3'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    expectHead("t4_stall", 32'h104);
    applyStimulus(1'b1, 32'h2000, 1'b1, 1'b1);
    expectHead("t4_redir", 32'h104);
    expectReq("t4_redir", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    discardSnap = discard_count;
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectEmpty("t4_after");
    expectReq("t4_after", 1'b1, 32'h2000);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("t4_discards", discard_count - discardSnap, 32'd3);
    checkOutput("t4_fetches", fetch_count, 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectEmpty("t4_wait");
    expectReq("t4_next", 1'b1, 32'h2004);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t4_new", 32'h2000);

    $display("[TB] back-to-back redirects, L=3");
    resetDut(3'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h4000, 1'b0, 1'b1);
    expectReq("t5_redir2", 1'b0, 32'h0);
    for (int c = 5; c <= 8; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      if (c == 5) expectReq("t5_first", 1'b1, 32'h4000);
      expectEmpty("t5_gap");
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t5_new", 32'h4000);

    $display("[TB] memory not ready for 4 cycles");
    resetDut(3'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int c = 3; c <= 6; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      expectReq("t6_hold", 1'b1, 32'h10C);
      if (c == 3)      expectHead("t6_h0", 32'h104);
      else if (c == 4) expectHead("t6_h1", 32'h108);
      else             expectEmpty("t6_dry");
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectReq("t6_resume", 1'b1, 32'h10C);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectEmpty("t6_wait");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t6_resume", 32'h10C);

    $display("[TB] PC wrap and unaligned redirect");
    resetDut(3'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectReq("t7_top", 1'b1, 32'hFFFF_FFFC);
    expectEmpty("t7_gap");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectReq("t7_wrap", 1'b1, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectReq("t7_next", 1'b1, 32'h0000_0004);
    expectHead("t7_top", 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t7_wrap", 32'h0000_0000);
    applyStimulus(1'b1, 32'h0000_1003, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectReq("t7_align", 1'b1, 32'h0000_1000);
    expectEmpty("t7_gap2");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    expectHead("t7_align", 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
